hubris: RTL and testbench
=========================

HUBRIS -- requirements
Module: hubris

Interface
REQ-001 Parameter REG_NUMBER, default 32: number of architectural integer registers, x0..x(REG_NUMBER-1).
REQ-002 Parameter INST_START_ADDR, default 32'h0000_0000: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 halt  output  1  high once the core has stopped executing; sticky until reset.
REQ-006 The design SHALL expose these hierarchical names:
- pc (32-bit register).
- register_file_instance.regfile[0..REG_NUMBER-1] (32-bit each).
- unified_memory_instance.inst_memory_instance.mem and unified_memory_instance.data_memory_instance.mem (8-bit byte arrays).
- Integer parameters MEMORY_WIDTH_IN_BYTE=4 and MEMORY_DEPTH_IN_WORD=1024 in both memory instances.

Function
REQ-007 The core SHALL execute RV32I base integer instructions single-cycle: one instruction fetched, executed and retired per rising clk edge while running.
REQ-008 Supported instructions SHALL be:
- LUI, AUIPC, JAL, JALR.
- BEQ, BNE, BLT, BGE, BLTU, BGEU.
- LB, LH, LW, LBU, LHU, SB, SH, SW.
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- FENCE as NOP, ECALL, EBREAK.
REQ-009 Instruction memory SHALL be byte-addressed and little-endian, 4096 bytes. Fetch reads mem[pc..pc+3], with the address taken modulo 4096 (pc[11:0]).
REQ-010 Data memory SHALL be a separate byte array, 4096 bytes, little-endian. All loads and stores access it at effective address modulo 4096; there is no access from data to instruction memory.
REQ-011 Loads SHALL complete combinationally within the cycle. Stores write on the rising edge. Only the addressed bytes change for SB and SH.
REQ-012 Misaligned halfword and word accesses SHALL access consecutive bytes (wrapping modulo 4096) without trapping.
REQ-013 x0 SHALL read as 0 always; writes to x0 are discarded.
REQ-014 Register writes SHALL occur on the rising edge. A source register read in the same cycle sees the old value.
REQ-015 Arithmetic SHALL be 32-bit modulo 2^32. Shift amount is rs2[4:0] or shamt[4:0]. SLT/SLTI compare signed; SLTU/SLTIU compare unsigned, with the immediate sign-extended first.
REQ-016 Next PC SHALL be:
- pc+4 by default.
- pc+imm for JAL and for taken branches.
- (rs1+imm) with bit0 cleared for JALR.
JAL/JALR write pc+4 to rd.
REQ-017 ECALL or EBREAK SHALL cause the following, all on that rising edge:
- halt is set to 1.
- pc holds the address of the ECALL/EBREAK instruction.
- no register or memory write.
REQ-018 While halt=1, pc, the register file and data memory SHALL remain frozen on every clk edge.
REQ-019 An illegal or unsupported opcode SHALL also halt, with the same behaviour as REQ-017.
REQ-020 A branch or jump target misaligned to 4 bytes SHALL be taken without trapping. Fetch uses pc[11:2] word-aligned bytes.

Reset
REQ-021 While reset=0, asynchronously and for as long as reset is held low:
- pc=INST_START_ADDR.
- halt=0.
- all regfile entries=0.
REQ-022 Instruction and data memory contents SHALL NOT be modified by reset, so preloaded programs and data survive it.
REQ-023 The first instruction, at INST_START_ADDR, SHALL execute on the first rising clk edge after reset returns to 1.
REQ-024 Asserting reset mid-execution or while halted SHALL immediately restore the REQ-021 state.

Verification
REQ-025 Program `addi x1,x0,5; addi x2,x1,-7; ecall` -> halt=1 after 3 executing edges, x1=5, x2=0xFFFFFFFE, pc=8.
REQ-026 Program `lui x1,0x12345; addi x1,x1,0x678; sw x1,16(x0); lb x2,17(x0); lhu x3,18(x0); ecall` -> data mem[16..19]=78,56,34,12; x2=0x56; x3=0x1234.
REQ-027 Counting loop: x1=0, x2=10, loop `addi x1,x1,1; bne x1,x2,-4`, then ebreak -> x1=10, halt=1, pc=address of ebreak; cycle count = 2 + 20 + 1.
REQ-028 Program `jal x1,8; ecall; jalr x0,0(x1)` -> jal writes x1=4, jalr returns to 4, ecall halts with pc=4.
REQ-029 Program `addi x0,x0,9; ecall` -> x0=0. Additionally, after halt, run 10 further clocks -> pc, regs and memory unchanged.
REQ-030 Pull reset low mid-loop -> pc=0, registers=0, halt=0 immediately with no clk edge needed. Data memory keeps the values written before reset.

Source files
------------

// File: rtl/hubris_if.sv
// hubris_if: byte-addressed 32-bit memory port between the core and one
// memory bank.
//   addr  - byte address; the bank uses only the low bits
//   wdata - store data, byte lane k goes to addr+k
//   be    - per-lane write enables; all zero means no write this cycle
//   rdata - combinational read of bytes addr..addr+3, little-endian
interface hubris_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;

  modport master (output addr, wdata, be, input rdata);
  modport slave  (input addr, wdata, be, output rdata);
endinterface

// File: rtl/hubris.sv
// hubris: single-cycle RV32I core with separate 4 KiB instruction and data
// byte memories. One instruction retires per rising clk edge until an
// ECALL, EBREAK or unsupported encoding, which freezes the core.
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous active-low reset (pc, halt, register file)
//   halt  - sticky "core stopped" flag, cleared only by reset

// Byte-array memory bank. Accesses wrap modulo the bank size, so misaligned
// halfwords and words simply touch consecutive bytes. No reset: contents
// survive core reset.
module hubris_byte_mem #(
  parameter int MEMORY_WIDTH_IN_BYTE = 4,
  parameter int MEMORY_DEPTH_IN_WORD = 1024
) (
  input logic     clk,
  hubris_if.slave bus
);
  localparam int BYTES = MEMORY_WIDTH_IN_BYTE * MEMORY_DEPTH_IN_WORD;
  localparam int AW    = $clog2(BYTES);

  logic [7:0]    mem [0:BYTES-1];
  logic [AW-1:0] base;

  assign base = bus.addr[AW-1:0];
  wire unused_addr_hi = ^bus.addr[31:AW];

  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < MEMORY_WIDTH_IN_BYTE; k++)
      bus.rdata[8*k +: 8] = mem[base + AW'(k)];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < MEMORY_WIDTH_IN_BYTE; k++)
      if (bus.be[k]) mem[base + AW'(k)] <= bus.wdata[8*k +: 8];
  end
endmodule

module hubris_unified_mem (
  input logic     clk,
  hubris_if.slave imem,
  hubris_if.slave dmem
);
  hubris_byte_mem #(.MEMORY_WIDTH_IN_BYTE(4), .MEMORY_DEPTH_IN_WORD(1024))
    inst_memory_instance (.clk(clk), .bus(imem));
  hubris_byte_mem #(.MEMORY_WIDTH_IN_BYTE(4), .MEMORY_DEPTH_IN_WORD(1024))
    data_memory_instance (.clk(clk), .bus(dmem));
endmodule

// Two async read ports, one write port. Entry 0 is never written, so x0
// stays zero without a read-side mux.
module hubris_regfile #(
  parameter int REG_NUMBER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regfile [0:REG_NUMBER-1];

  assign rdata1 = (32'(raddr1) < REG_NUMBER) ? regfile[raddr1] : '0;
  assign rdata2 = (32'(raddr2) < REG_NUMBER) ? regfile[raddr2] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUMBER; i++) regfile[i] <= '0;
    end else if (we && waddr != 5'd0 && 32'(waddr) < REG_NUMBER) begin
      regfile[waddr] <= wdata;
    end
  end
endmodule

module hubris #(
  parameter int          REG_NUMBER      = 32,
  parameter logic [31:0] INST_START_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  output logic halt
);
  typedef enum logic {S_RUN, S_HALT} state_e;

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f,
    OP_JALR = 7'h67, OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23,
    OP_IMM = 7'h13, OP_REG = 7'h33, OP_FENCE = 7'h0f;

  state_e      state_q, state_d;
  logic [31:0] pc, pc_d;
  logic        commit, stop;

  hubris_if imem_bus ();
  hubris_if dmem_bus ();

  logic [31:0] inst, rs1v, rs2v, rf_wd, daddr, alu_b, alu_r, ld;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2, sh;
  logic [2:0]  f3;
  logic [3:0]  be_raw;
  logic        rf_we, take, f7_ok;

  hubris_unified_mem unified_memory_instance (
    .clk(clk), .imem(imem_bus), .dmem(dmem_bus));

  hubris_regfile #(.REG_NUMBER(REG_NUMBER)) register_file_instance (
    .clk(clk), .reset(reset), .we(commit && rf_we), .waddr(rd), .wdata(rf_wd),
    .raddr1(rs1), .raddr2(rs2), .rdata1(rs1v), .rdata2(rs2v));

  // Fetch ignores pc[1:0]: a misaligned target fetches its enclosing word.
  assign imem_bus.addr  = {pc[31:2], 2'b00};
  assign imem_bus.wdata = '0;
  assign imem_bus.be    = '0;

  // Reset gates stores too, since the memory banks have no reset of their own.
  assign dmem_bus.addr  = daddr;
  assign dmem_bus.wdata = rs2v;
  assign dmem_bus.be    = (commit && reset) ? be_raw : 4'b0000;

  assign inst   = imem_bus.rdata;
  assign ld     = dmem_bus.rdata;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Shared ALU for OP and OP-IMM; funct7 bit 5 selects SUB/SRA.
  assign alu_b = (opcode == OP_REG) ? rs2v : imm_i;
  assign sh    = alu_b[4:0];
  always_comb begin
    alu_r = '0;
    unique case (f3)
      3'd0: alu_r = (opcode == OP_REG && f7[5]) ? rs1v - alu_b : rs1v + alu_b;
      3'd1: alu_r = rs1v << sh;
      3'd2: alu_r = {31'b0, $signed(rs1v) < $signed(alu_b)};
      3'd3: alu_r = {31'b0, rs1v < alu_b};
      3'd4: alu_r = rs1v ^ alu_b;
      3'd5: alu_r = f7[5] ? 32'($signed(rs1v) >>> sh) : rs1v >> sh;
      3'd6: alu_r = rs1v | alu_b;
      3'd7: alu_r = rs1v & alu_b;
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    if (opcode == OP_REG)
      f7_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (f3 == 3'd1)
      f7_ok = (f7 == 7'h00);
    else if (f3 == 3'd5)
      f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
    else
      f7_ok = 1'b1;
  end

  always_comb begin
    unique case (f3)
      3'd0: take = (rs1v == rs2v);
      3'd1: take = (rs1v != rs2v);
      3'd4: take = ($signed(rs1v) <  $signed(rs2v));
      3'd5: take = ($signed(rs1v) >= $signed(rs2v));
      3'd6: take = (rs1v <  rs2v);
      3'd7: take = (rs1v >= rs2v);
      default: take = 1'b0;
    endcase
  end

  // Decode / execute. Any unrecognised encoding (and every SYSTEM opcode,
  // which covers ECALL/EBREAK) raises stop.
  always_comb begin
    pc_d   = pc + 32'd4;
    rf_we  = 1'b0;
    rf_wd  = '0;
    be_raw = 4'b0000;
    daddr  = rs1v + imm_i;
    stop   = 1'b0;
    unique case (opcode)
      OP_LUI:   begin rf_we = 1'b1; rf_wd = imm_u; end
      OP_AUIPC: begin rf_we = 1'b1; rf_wd = pc + imm_u; end
      OP_JAL:   begin rf_we = 1'b1; rf_wd = pc + 32'd4; pc_d = pc + imm_j; end
      OP_JALR: begin
        stop  = (f3 != 3'd0);
        rf_we = 1'b1;
        rf_wd = pc + 32'd4;
        pc_d  = (rs1v + imm_i) & ~32'd1;
      end
      OP_BR: begin
        stop = (f3 == 3'd2) || (f3 == 3'd3);
        if (take) pc_d = pc + imm_b;
      end
      OP_LD: begin
        rf_we = 1'b1;
        unique case (f3)
          3'd0: rf_wd = {{24{ld[7]}}, ld[7:0]};
          3'd1: rf_wd = {{16{ld[15]}}, ld[15:0]};
          3'd2: rf_wd = ld;
          3'd4: rf_wd = {24'b0, ld[7:0]};
          3'd5: rf_wd = {16'b0, ld[15:0]};
          default: stop = 1'b1;
        endcase
      end
      OP_ST: begin
        daddr = rs1v + imm_s;
        unique case (f3)
          3'd0: be_raw = 4'b0001;
          3'd1: be_raw = 4'b0011;
          3'd2: be_raw = 4'b1111;
          default: stop = 1'b1;
        endcase
      end
      OP_IMM, OP_REG: begin rf_we = 1'b1; rf_wd = alu_r; stop = !f7_ok; end
      OP_FENCE: ;
      default:  stop = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    if (state_q == S_RUN) begin
      if (stop) state_d = S_HALT;
      else      commit  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      pc      <= INST_START_ADDR;
    end else begin
      state_q <= state_d;
      if (commit) pc <= pc_d;
    end
  end

  assign halt = (state_q == S_HALT);
endmodule

// File: tb/tb_hubris.sv
module tb_hubris;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halt;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  hubris #(.REG_NUMBER(32), .INST_START_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .halt(halt));

  always #5 clk = ~clk;

  typedef enum int {K_PC, K_REG, K_DMEM, K_HALT, K_CYC} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(7'h13, 3'd0, rd, rs1, imm);
  endfunction

  task automatic sb_push(input string tag, input kind_e k, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input kind_e k, input int idx);
    case (k)
      K_PC:   return dut.pc;
      K_REG:  return dut.register_file_instance.regfile[5'(idx)];
      K_DMEM: return {24'b0, dut.unified_memory_instance.data_memory_instance.mem[12'(idx)]};
      K_HALT: return {31'b0, halt};
      K_CYC:  return 32'(cyc);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.kind, e.idx), e.val);
    end
  endtask

  // Hold reset, optionally wipe both memories, load prog at address 0,
  // check the reset state, then release on a falling edge.
  task automatic start(input string name, input bit wipe);
    reset = 1'b0;
    #1;
    if (wipe) begin
      for (int i = 0; i < 4096; i++) begin
        dut.unified_memory_instance.inst_memory_instance.mem[i] = 8'h00;
        dut.unified_memory_instance.data_memory_instance.mem[i] = 8'h00;
      end
    end
    for (int i = 0; i < prog.size(); i++)
      for (int b = 0; b < 4; b++)
        dut.unified_memory_instance.inst_memory_instance.mem[4*i+b] = prog[i][8*b +: 8];
    sb_push({name, "/rst_pc"},   K_PC,   0, 32'h0);
    sb_push({name, "/rst_halt"}, K_HALT, 0, 32'h0);
    sb_push({name, "/rst_x1"},   K_REG,  1, 32'h0);
    sb_drain();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int max);
    cyc = 0;
    while (!halt && cyc < max) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    // basic ALU and halt timing
    prog = '{addi(1, 0, 5), addi(2, 1, -7), ECALL};
    start("t1", 1'b1);
    run(100);
    sb_push("t1/cyc", K_CYC, 0, 32'd3);
    sb_push("t1/halt", K_HALT, 0, 32'd1);
    sb_push("t1/x1", K_REG, 1, 32'd5);
    sb_push("t1/x2", K_REG, 2, 32'hFFFF_FFFE);
    sb_push("t1/pc", K_PC, 0, 32'd8);
    sb_drain();

    // stores, sub-word loads, then frozen after halt
    prog = '{enc_i(7'h37, 3'd0, 1, 0, 0) | 32'h1234_5000, addi(1, 1, 32'h678),
             enc_s(3'd2, 0, 1, 16), enc_i(7'h03, 3'd0, 2, 0, 17),
             enc_i(7'h03, 3'd5, 3, 0, 18), ECALL};
    start("t2", 1'b1);
    run(100);
    sb_push("t2/x1", K_REG, 1, 32'h1234_5678);
    sb_push("t2/x2", K_REG, 2, 32'h56);
    sb_push("t2/x3", K_REG, 3, 32'h1234);
    sb_push("t2/m16", K_DMEM, 16, 32'h78);
    sb_push("t2/m17", K_DMEM, 17, 32'h56);
    sb_push("t2/m18", K_DMEM, 18, 32'h34);
    sb_push("t2/m19", K_DMEM, 19, 32'h12);
    sb_push("t2/pc", K_PC, 0, 32'd20);
    sb_drain();
    repeat (10) @(posedge clk);
    @(negedge clk);
    sb_push("t2/frz_pc", K_PC, 0, 32'd20);
    sb_push("t2/frz_halt", K_HALT, 0, 32'd1);
    sb_push("t2/frz_x1", K_REG, 1, 32'h1234_5678);
    sb_push("t2/frz_m16", K_DMEM, 16, 32'h78);
    sb_drain();

    // sign handling, wrap-around store/load, compares, shifts, branches
    prog = '{addi(4, 0, -128), enc_s(3'd0, 0, 4, 20),
             enc_i(7'h03, 3'd0, 5, 0, 20), enc_i(7'h03, 3'd4, 6, 0, 20),
             addi(7, 0, -2), enc_s(3'd2, 7, 4, 0), enc_i(7'h03, 3'd2, 8, 7, 0),
             enc_r(7'h00, 0, 4, 3'd2, 9), enc_r(7'h00, 0, 4, 3'd3, 10),
             enc_i(7'h13, 3'd5, 11, 4, 32'h404), enc_i(7'h13, 3'd5, 12, 4, 28),
             enc_r(7'h20, 4, 0, 3'd0, 13), enc_i(7'h13, 3'd3, 14, 0, -1),
             enc_b(3'd4, 4, 0, 8), addi(15, 0, 1),
             enc_b(3'd7, 4, 0, 8), addi(16, 0, 1), ECALL};
    start("t3", 1'b1);
    run(100);
    sb_push("t3/cyc", K_CYC, 0, 32'd16);
    sb_push("t3/pc", K_PC, 0, 32'd68);
    sb_push("t3/lb_neg", K_REG, 5, 32'hFFFF_FF80);
    sb_push("t3/lbu", K_REG, 6, 32'h80);
    sb_push("t3/lw_wrap", K_REG, 8, 32'hFFFF_FF80);
    sb_push("t3/m4094", K_DMEM, 4094, 32'h80);
    sb_push("t3/m0", K_DMEM, 0, 32'hFF);
    sb_push("t3/slt", K_REG, 9, 32'd1);
    sb_push("t3/sltu", K_REG, 10, 32'd0);
    sb_push("t3/srai", K_REG, 11, 32'hFFFF_FFF8);
    sb_push("t3/srli", K_REG, 12, 32'hF);
    sb_push("t3/sub", K_REG, 13, 32'h80);
    sb_push("t3/sltiu", K_REG, 14, 32'd1);
    sb_push("t3/blt_skip", K_REG, 15, 32'd0);
    sb_push("t3/bgeu_skip", K_REG, 16, 32'd0);
    sb_drain();

    // counting loop
    prog = '{addi(1, 0, 0), addi(2, 0, 10), addi(1, 1, 1), enc_b(3'd1, 1, 2, -4), EBREAK};
    start("t4", 1'b1);
    run(200);
    sb_push("t4/cyc", K_CYC, 0, 32'd23);
    sb_push("t4/x1", K_REG, 1, 32'd10);
    sb_push("t4/halt", K_HALT, 0, 32'd1);
    sb_push("t4/pc", K_PC, 0, 32'd16);
    sb_drain();

    // jal / jalr
    prog = '{enc_j(1, 8), ECALL, enc_i(7'h67, 3'd0, 0, 1, 0)};
    start("t5", 1'b1);
    run(100);
    sb_push("t5/cyc", K_CYC, 0, 32'd3);
    sb_push("t5/x1", K_REG, 1, 32'd4);
    sb_push("t5/pc", K_PC, 0, 32'd4);
    sb_drain();

    // x0 stays zero; halted state frozen
    prog = '{addi(0, 0, 9), ECALL};
    start("t6", 1'b1);
    run(100);
    sb_push("t6/x0", K_REG, 0, 32'd0);
    sb_push("t6/pc", K_PC, 0, 32'd4);
    sb_drain();
    repeat (10) @(posedge clk);
    @(negedge clk);
    sb_push("t6/frz_pc", K_PC, 0, 32'd4);
    sb_push("t6/frz_halt", K_HALT, 0, 32'd1);
    sb_push("t6/frz_x0", K_REG, 0, 32'd0);
    sb_drain();

    // illegal opcode halts without retiring
    prog = '{addi(1, 0, 3), 32'hFFFF_FFFF, addi(1, 0, 7)};
    start("t7", 1'b1);
    run(100);
    sb_push("t7/cyc", K_CYC, 0, 32'd2);
    sb_push("t7/pc", K_PC, 0, 32'd4);
    sb_push("t7/x1", K_REG, 1, 32'd3);
    sb_push("t7/halt", K_HALT, 0, 32'd1);
    sb_drain();

    // async reset mid-loop; data memory survives
    prog = '{addi(2, 0, 10), enc_s(3'd2, 0, 2, 32), addi(1, 1, 1),
             enc_b(3'd1, 1, 2, -4), EBREAK};
    start("t8", 1'b1);
    repeat (6) @(posedge clk);
    #1;
    sb_push("t8/pre_x1", K_REG, 1, 32'd2);
    sb_push("t8/pre_m32", K_DMEM, 32, 32'd10);
    sb_drain();
    #1 reset = 1'b0;
    #1;
    sb_push("t8/async_pc", K_PC, 0, 32'd0);
    sb_push("t8/async_halt", K_HALT, 0, 32'd0);
    sb_push("t8/async_x1", K_REG, 1, 32'd0);
    sb_push("t8/async_x2", K_REG, 2, 32'd0);
    sb_push("t8/keep_m32", K_DMEM, 32, 32'd10);
    sb_drain();
    start("t8b", 1'b0);
    run(200);
    sb_push("t8b/cyc", K_CYC, 0, 32'd23);
    sb_push("t8b/x1", K_REG, 1, 32'd10);
    sb_push("t8b/pc", K_PC, 0, 32'd16);
    sb_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
